// File: rtl/cmd_queue_frontend_pkg.sv
// Shared types and constants for the command queue front-end and its arbiter.
package cmd_queue_frontend_pkg;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] arg;
    } cmd_t;

    localparam int CMDQ_DEPTH           = 8;
    localparam int CMDQ_SRC             = 2;
    localparam int CMDQ_MAX_OUTSTANDING = 16;

    localparam int ERR_POP_UNDERFLOW    = 0;
    localparam int ERR_FINISH_UNDERFLOW = 1;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmd_queue_frontend_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner
// only when the grant is actually used (i_advance).
module rr_arbiter
    import cmd_queue_frontend_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant_onehot,
    output logic [IW-1:0] o_grant_idx
);

    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] rr_ptr_d;

    always_comb begin
        int   j;
        logic found;
        j              = 0;
        found          = 1'b0;
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && i_req[j]) begin
                found             = 1'b1;
                o_grant_onehot[j] = 1'b1;
                o_grant_idx       = IW'(j);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (i_advance) begin
            rr_ptr_d = (int'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + IW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/cmd_queue_frontend.sv
// Command front-end: round-robin intake from NUM_SRC sources into a show-ahead FIFO,
// gated by an outstanding-command credit counter, with flush and sticky error flags.
module cmd_queue_frontend
    import cmd_queue_frontend_pkg::*;
#(
    parameter  int NUM_SRC         = CMDQ_SRC,
    parameter  int DEPTH           = CMDQ_DEPTH,
    parameter  int MAX_OUTSTANDING = CMDQ_MAX_OUTSTANDING,
    localparam int SW              = idx_width(NUM_SRC),
    localparam int PW              = $clog2(DEPTH),
    localparam int LW              = $clog2(DEPTH + 1),
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  cmd_t               i_cmd [NUM_SRC],
    input  logic [NUM_SRC-1:0] i_cmd_valid,
    output logic [NUM_SRC-1:0] o_cmd_ready,
    output cmd_t               o_queue_cmd,
    output logic               o_queue_empty,
    input  logic               i_rd_queue,
    input  logic               i_finished_task,
    input  logic               i_flush,
    output logic [LW-1:0]      o_level,
    output logic [OW-1:0]      o_outstanding,
    output logic               o_idle,
    output logic [1:0]         o_err
);

    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [1:0]    err_q, err_d;
    logic          empty_q, idle_q;

    logic [NUM_SRC-1:0] grant;
    logic [SW-1:0]      grant_idx;
    logic               can_push, push, pop;

    // Gating with i_rstn keeps ready low while reset is held.
    assign can_push = i_rstn && (level_q != LW'(DEPTH))
                    && (outstanding_q < OW'(MAX_OUTSTANDING)) && !i_flush;
    assign push     = can_push && (|i_cmd_valid);
    assign pop      = i_rd_queue && !empty_q && !i_flush;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_req          (i_cmd_valid),
        .i_advance      (push),
        .o_grant_onehot (grant),
        .o_grant_idx    (grant_idx)
    );

    always_comb begin
        int out_next;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        err_d    = err_q;
        out_next = int'(outstanding_q);

        if (i_rd_queue && empty_q) begin
            err_d[ERR_POP_UNDERFLOW] = 1'b1;
        end

        if (i_flush) begin
            // Dropped entries were never issued, so their credits come back now.
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
            out_next = int'(outstanding_q) - int'(level_q);
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                out_next = out_next + 1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            level_d = level_q + LW'(push) - LW'(pop);
        end

        if (i_finished_task) begin
            if (out_next == 0) begin
                err_d[ERR_FINISH_UNDERFLOW] = 1'b1;
            end else begin
                out_next = out_next - 1;
            end
        end
        outstanding_d = OW'(out_next);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            outstanding_q <= '0;
            err_q         <= '0;
            empty_q       <= 1'b1;
            idle_q        <= 1'b1;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            empty_q       <= (level_d == '0);
            idle_q        <= (level_d == '0) && (outstanding_d == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_cmd[grant_idx];
        end
    end

    assign o_cmd_ready   = can_push ? grant : '0;
    assign o_queue_cmd   = mem_q[rd_ptr_q];
    assign o_queue_empty = empty_q;
    assign o_level       = level_q;
    assign o_outstanding = outstanding_q;
    assign o_idle        = idle_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_cmd_queue_frontend.sv
// Directed bench: a 1-source/DEPTH=4/MAX=4 instance and a 3-source/DEPTH=8/MAX=16 instance.
module tb_cmd_queue_frontend;
    import cmd_queue_frontend_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   errors = 0;
    int   checks = 0;

    cmd_t       a_cmd [1];
    logic [0:0] a_valid, a_ready;
    cmd_t       a_qcmd;
    logic       a_empty, a_rd, a_fin, a_flush, a_idle;
    logic [2:0] a_level, a_out;
    logic [1:0] a_err;

    cmd_t       b_cmd [3];
    logic [2:0] b_valid, b_ready;
    cmd_t       b_qcmd;
    logic       b_empty, b_rd, b_fin, b_flush, b_idle;
    logic [3:0] b_level;
    logic [4:0] b_out;
    logic [1:0] b_err;

    cmd_queue_frontend #(.NUM_SRC(1), .DEPTH(4), .MAX_OUTSTANDING(4)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_cmd(a_cmd), .i_cmd_valid(a_valid),
        .o_cmd_ready(a_ready), .o_queue_cmd(a_qcmd), .o_queue_empty(a_empty),
        .i_rd_queue(a_rd), .i_finished_task(a_fin), .i_flush(a_flush),
        .o_level(a_level), .o_outstanding(a_out), .o_idle(a_idle), .o_err(a_err)
    );

    cmd_queue_frontend #(.NUM_SRC(3), .DEPTH(8), .MAX_OUTSTANDING(16)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_cmd(b_cmd), .i_cmd_valid(b_valid),
        .o_cmd_ready(b_ready), .o_queue_cmd(b_qcmd), .o_queue_empty(b_empty),
        .i_rd_queue(b_rd), .i_finished_task(b_fin), .i_flush(b_flush),
        .o_level(b_level), .o_outstanding(b_out), .o_idle(b_idle), .o_err(b_err)
    );

    function automatic cmd_t mk(input int op, input int arg);
        cmd_t c;
        c.opcode = 4'(op);
        c.arg    = 12'(arg);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        a_cmd[0] = '0; a_valid = '0; a_rd = 0; a_fin = 0; a_flush = 0;
        for (int s = 0; s < 3; s++) b_cmd[s] = '0;
        b_valid = '0; b_rd = 0; b_fin = 0; b_flush = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        a_valid = 1'b1;
        b_valid = 3'b111;
        tick();
        tick();
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL reset_b_ready got=%b exp=000", b_ready); end
        checks++; if (a_level !== 3'd0 || a_out !== 3'd0) begin errors++; $display("FAIL reset_a_counts level=%0d out=%0d exp=0/0", a_level, a_out); end
        checks++; if (a_empty !== 1'b1 || a_idle !== 1'b1) begin errors++; $display("FAIL reset_a_flags empty=%b idle=%b exp=1/1", a_empty, a_idle); end
        checks++; if (a_err !== 2'b00 || b_err !== 2'b00) begin errors++; $display("FAIL reset_err a=%b b=%b exp=00", a_err, b_err); end
        checks++; if (b_out !== 5'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL reset_b out=%0d empty=%b exp=0/1", b_out, b_empty); end
        $display("test_reset: reset values examined");
        clear_inputs();
    endtask

    task automatic test_fill_and_credit();
        cmd_t exp_q [4];
        do_reset();
        for (int i = 0; i < 4; i++) exp_q[i] = mk(i + 1, 12'h0A0 + i);
        for (int i = 0; i < 4; i++) begin
            a_cmd[0] = exp_q[i]; a_valid = 1'b1; #1;
            checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, a_ready); end
            $display("fill: push %0d cmd=%h", i, exp_q[i]);
            tick();
        end
        a_cmd[0] = mk(15, 12'hFFF); #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", a_ready); end
        checks++; if (a_level !== 3'd4 || a_out !== 3'd4) begin errors++; $display("FAIL fill_level level=%0d out=%0d exp=4/4", a_level, a_out); end
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_empty !== 1'b0 || a_qcmd !== exp_q[i]) begin errors++; $display("FAIL fill_head[%0d] empty=%b got=%h exp=%h", i, a_empty, a_qcmd, exp_q[i]); end
            $display("fill: pop %0d head=%h", i, a_qcmd);
            a_rd = 1'b1;
            tick();
        end
        a_rd = 1'b0;
        checks++; if (a_empty !== 1'b1 || a_level !== 3'd0 || a_out !== 3'd4) begin errors++; $display("FAIL drain empty=%b level=%0d out=%0d exp=1/0/4", a_empty, a_level, a_out); end
        a_valid = 1'b1; #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL credit_block_ready got=%b exp=0", a_ready); end
        a_valid = 1'b0;
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        a_valid = 1'b1; #1;
        checks++; if (a_out !== 3'd3 || a_ready !== 1'b1) begin errors++; $display("FAIL credit_return out=%0d ready=%b exp=3/1", a_out, a_ready); end
        a_valid = 1'b0;
        a_fin = 1'b1;
        repeat (3) tick();
        a_fin = 1'b0;
        checks++; if (a_out !== 3'd0 || a_idle !== 1'b1 || a_err !== 2'b00) begin errors++; $display("FAIL credit_drain out=%0d idle=%b err=%b exp=0/1/00", a_out, a_idle, a_err); end
    endtask

    task automatic test_push_pop_same_cycle();
        cmd_t p [3];
        do_reset();
        for (int i = 0; i < 3; i++) p[i] = mk(4 + i, 12'h300 + i);
        a_valid = 1'b1;
        a_cmd[0] = p[0]; tick();
        a_cmd[0] = p[1]; tick();
        a_valid = 1'b0;
        checks++; if (a_level !== 3'd2 || a_qcmd !== p[0]) begin errors++; $display("FAIL pp_pre level=%0d head=%h exp=2/%h", a_level, a_qcmd, p[0]); end
        a_cmd[0] = p[2]; a_valid = 1'b1; a_rd = 1'b1; #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL pp_ready got=%b exp=1", a_ready); end
        tick();
        a_valid = 1'b0; a_rd = 1'b0;
        $display("push_pop: level=%0d head=%h out=%0d", a_level, a_qcmd, a_out);
        checks++; if (a_level !== 3'd2 || a_qcmd !== p[1] || a_out !== 3'd3) begin errors++; $display("FAIL pp_post level=%0d head=%h out=%0d exp=2/%h/3", a_level, a_qcmd, a_out, p[1]); end
        a_rd = 1'b1;
        tick();
        checks++; if (a_level !== 3'd1 || a_qcmd !== p[2]) begin errors++; $display("FAIL pp_last level=%0d head=%h exp=1/%h", a_level, a_qcmd, p[2]); end
        tick();
        a_rd = 1'b0;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL pp_empty got=%b exp=1", a_empty); end
    endtask

    task automatic test_errors();
        do_reset();
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        $display("errors: pop on empty err=%b", a_err);
        checks++; if (a_err !== 2'b01 || a_level !== 3'd0 || a_out !== 3'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL err_pop err=%b level=%0d out=%0d empty=%b exp=01/0/0/1", a_err, a_level, a_out, a_empty); end
        a_fin = 1'b1;
        tick();
        a_fin = 1'b0;
        $display("errors: finish at zero err=%b", a_err);
        checks++; if (a_err !== 2'b11 || a_out !== 3'd0) begin errors++; $display("FAIL err_finish err=%b out=%0d exp=11/0", a_err, a_out); end
        tick();
        checks++; if (a_err !== 2'b11) begin errors++; $display("FAIL err_sticky err=%b exp=11", a_err); end
    endtask

    task automatic test_round_robin();
        int         seq [10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
        logic [2:0] exp_g;
        do_reset();
        for (int s = 0; s < 3; s++) b_cmd[s] = mk(8 + s, 100 + s);
        b_valid = 3'b111;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) b_valid = 3'b101;
            b_rd = (i > 0);
            exp_g = 3'b001 << seq[i];
            #1;
            $display("rr: cycle %0d grant=%b", i, b_ready);
            checks++; if (b_ready !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, b_ready, exp_g); end
            if (i > 0) begin
                checks++; if (b_empty !== 1'b0 || b_qcmd !== b_cmd[seq[i-1]]) begin errors++; $display("FAIL rr_head[%0d] empty=%b got=%h exp=%h", i, b_empty, b_qcmd, b_cmd[seq[i-1]]); end
            end
            tick();
        end
        b_valid = 3'b000;
        checks++; if (b_qcmd !== b_cmd[seq[9]]) begin errors++; $display("FAIL rr_head_last got=%h exp=%h", b_qcmd, b_cmd[seq[9]]); end
        tick();
        b_rd = 1'b0;
        checks++; if (b_empty !== 1'b1 || b_out !== 5'd10 || b_err !== 2'b00) begin errors++; $display("FAIL rr_end empty=%b out=%0d err=%b exp=1/10/00", b_empty, b_out, b_err); end
    endtask

    task automatic test_flush();
        do_reset();
        b_cmd[0] = mk(3, 12'h555);
        b_valid = 3'b001;
        repeat (5) tick();
        b_valid = 3'b000;
        checks++; if (b_level !== 4'd5 || b_out !== 5'd5) begin errors++; $display("FAIL flush_fill level=%0d out=%0d exp=5/5", b_level, b_out); end
        b_rd = 1'b1;
        repeat (2) tick();
        b_rd = 1'b0;
        checks++; if (b_level !== 4'd3 || b_out !== 5'd5) begin errors++; $display("FAIL flush_pre level=%0d out=%0d exp=3/5", b_level, b_out); end
        b_flush = 1'b1; b_fin = 1'b1; b_valid = 3'b001; #1;
        checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL flush_ready got=%b exp=000", b_ready); end
        tick();
        b_flush = 1'b0; b_fin = 1'b0; b_valid = 3'b000;
        $display("flush: level=%0d out=%0d empty=%b", b_level, b_out, b_empty);
        checks++; if (b_level !== 4'd0 || b_out !== 5'd1 || b_empty !== 1'b1 || b_idle !== 1'b0) begin errors++; $display("FAIL flush_post level=%0d out=%0d empty=%b idle=%b exp=0/1/1/0", b_level, b_out, b_empty, b_idle); end
        checks++; if (b_err !== 2'b00) begin errors++; $display("FAIL flush_err got=%b exp=00", b_err); end
        b_fin = 1'b1;
        tick();
        b_fin = 1'b0;
        checks++; if (b_out !== 5'd0 || b_idle !== 1'b1) begin errors++; $display("FAIL flush_final out=%0d idle=%b exp=0/1", b_out, b_idle); end
    endtask

    task automatic test_async_reset();
        do_reset();
        a_cmd[0] = mk(1, 1); a_valid = 1'b1;
        for (int s = 0; s < 3; s++) b_cmd[s] = mk(2, s);
        b_valid = 3'b111;
        repeat (3) tick();
        checks++; if (b_level !== 4'd3 || a_level !== 3'd3) begin errors++; $display("FAIL burst_level a=%0d b=%0d exp=3/3", a_level, b_level); end
        #2;
        rstn = 1'b0;
        #1;
        $display("async_reset: a_level=%0d b_level=%0d b_out=%0d", a_level, b_level, b_out);
        checks++; if (b_level !== 4'd0 || b_out !== 5'd0 || b_empty !== 1'b1 || b_idle !== 1'b1) begin errors++; $display("FAIL areset_b level=%0d out=%0d empty=%b idle=%b exp=0/0/1/1", b_level, b_out, b_empty, b_idle); end
        checks++; if (a_level !== 3'd0 || a_empty !== 1'b1 || a_ready !== 1'b0 || b_ready !== 3'b000) begin errors++; $display("FAIL areset_a level=%0d empty=%b a_ready=%b b_ready=%b exp=0/1/0/000", a_level, a_empty, a_ready, b_ready); end
        @(negedge clk);
        clear_inputs();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_fill_and_credit();
        test_push_pop_same_cycle();
        test_errors();
        test_round_robin();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
